fetch_queue: RTL and testbench

//  Instruction-fetch stage feeding the REG/DEC pipe of the pipelined cpu.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and the {pc, instruction} entry type used by the fetch stage.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries with push/pop/flush and async active-low reset.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  fetch_entry_t         mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, imem drive, redirect/flush priority and the entry FIFO.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] PC_RESET = 64'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        perf_stall_cyc,
  output logic [31:0]        perf_flush_cnt,
`endif
  output logic               fetch_full
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              push;
  logic              pop;
  logic              empty;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  // Redirect wins over everything: no push or pop in a flush cycle.
  assign pop  = dec_valid & dec_ready & ~redirect_valid;
  assign push = fetch_en & ~redirect_valid & (~fetch_full | pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = imem_instr;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~64'd3;
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fetch_full),
    .empty   (empty)
  );

  assign imem_addr = pc_q;
  assign dec_valid = ~empty;
  assign dec_instr = head.instr;
  assign dec_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic stall_inc;
  assign stall_inc = fetch_en & fetch_full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_inc && (perf_stall_cyc != 32'hFFFF_FFFF)) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
      if (redirect_valid && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: queue-based reference model plus directed corner cases.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic               clk;
  logic               rst_n;
  logic               fetch_en;
  logic [63:0]        imem_addr;
  logic [31:0]        imem_instr;
  logic               redirect_valid;
  logic [63:0]        redirect_pc;
  logic               dec_valid;
  logic               dec_ready;
  logic [31:0]        dec_instr;
  logic [63:0]        dec_pc;
  logic               fetch_full;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_stall_cyc;
  logic [31:0]        perf_flush_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .PC_RESET (64'd0)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .fetch_full     (fetch_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] imem_f(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  assign imem_instr = imem_f(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents are the expected future dec_* heads.
  fetch_entry_t exp_q[$];
  logic [63:0]  m_pc;
  logic [31:0]  m_stall;
  logic [31:0]  m_flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_pc    = 64'd0;
      m_stall = 32'd0;
      m_flush = 32'd0;
    end else begin
      automatic bit           m_full = (exp_q.size() == DEPTH);
      automatic bit           m_pop  = (exp_q.size() != 0) && dec_ready && !redirect_valid;
      automatic bit           m_push = fetch_en && !redirect_valid && (!m_full || m_pop);
      automatic fetch_entry_t e;
      if (fetch_en && m_full && !m_pop && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (redirect_valid) begin
        if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        exp_q.delete();
        m_pc = {redirect_pc[63:2], 2'b00};
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) begin
          e.pc    = m_pc;
          e.instr = imem_f(m_pc);
          exp_q.push_back(e);
          m_pc = m_pc + 64'd4;
        end
      end
    end
  end

  // Monitor: compare presented outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
      chk("fetch_full", 64'(fetch_full), 64'(exp_q.size() == DEPTH));
      if (exp_q.size() != 0) begin
        chk("dec_pc", dec_pc, exp_q[0].pc);
        chk("dec_instr", 64'(dec_instr), 64'(exp_q[0].instr));
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_stall_cyc", 64'(perf_stall_cyc), 64'(m_stall));
      chk("perf_flush_cnt", 64'(perf_flush_cnt), 64'(m_flush));
`endif
    end
  end

  // Inputs change just after negedge; return just after the consuming posedge.
  task automatic step(input bit fe, input bit rdy, input bit rv, input logic [63:0] rp);
    @(negedge clk);
    #1;
    fetch_en       = fe;
    dec_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    chk("rst_fetch_full", 64'(fetch_full), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b1;
    fetch_en       = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_dec_valid", 64'(dec_valid), 64'd0);
    chk("reset_dec_instr", 64'(dec_instr), 64'd0);
    chk("reset_dec_pc", dec_pc, 64'd0);
    chk("reset_fetch_full", 64'(fetch_full), 64'd0);
    chk("reset_imem_addr", imem_addr, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming: one instruction per cycle.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 64'd0);

    // Back-pressure until full, then a single pop at full.
    async_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 64'd0);
    chk("full_flag", 64'(fetch_full), 64'd1);
    chk("full_pc_hold", imem_addr, 64'd16);
    chk("full_head_pc", dec_pc, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("full_stall_cnt", 64'(perf_stall_cyc), 64'd2);
`endif
    step(1'b1, 1'b1, 1'b0, 64'd0);
    chk("popfull_flag", 64'(fetch_full), 64'd1);
    chk("popfull_pc", imem_addr, 64'd20);
    chk("popfull_head", dec_pc, 64'd4);

    // Redirect with three entries queued; low PC bits dropped.
    step(1'b0, 1'b1, 1'b0, 64'd0);
    step(1'b1, 1'b0, 1'b1, 64'h1003);
    chk("redir_valid", 64'(dec_valid), 64'd0);
    chk("redir_addr", imem_addr, 64'h1000);
`ifdef FETCH_PERF_CNT_EN
    chk("redir_flush_cnt", 64'(perf_flush_cnt), 64'd1);
`endif
    step(1'b1, 1'b0, 1'b0, 64'd0);
    chk("redir_head", dec_pc, 64'h1000);

    // Redirect coinciding with dec_ready: pop discarded, no push.
    step(1'b1, 1'b1, 1'b1, 64'h2000);
    chk("redir_pop_valid", 64'(dec_valid), 64'd0);
    chk("redir_pop_addr", imem_addr, 64'h2000);

    // Redirect while fetch disabled, then PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("redir_nofetch", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1'b1, 1'b0, 1'b0, 64'd0);
    step(1'b1, 1'b0, 1'b0, 64'd0);
    chk("pc_wrap", imem_addr, 64'd0);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
           {$urandom, $urandom});
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
